// File: rtl/lsu_pkg.sv
// Shared opcode/func3 encodings, FSM state type and access-size helpers for the load/store unit.
package lsu_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;
    localparam logic [7:0] MASK_D = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEM_REQ,
        ST_MEM_WAIT,
        ST_OUT
    } lsu_state_e;

    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   return MASK_B;
            2'b01:   return MASK_H;
            2'b10:   return MASK_W;
            default: return MASK_D;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] off);
        case (sz)
            2'b00:   return 1'b0;
            2'b01:   return off[0];
            2'b10:   return |off[1:0];
            default: return |off[2:0];
        endcase
    endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational load alignment: shifts the addressed bytes down to lane 0 and sign/zero-extends.
module load_extract
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic [2:0]            i_offset,
    input  logic [2:0]            i_func3,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [DATA_WIDTH-1:0] w_shifted;

    assign w_shifted = i_rdata >> {i_offset, 3'b000};

    always_comb begin
        o_data = '0;
        case (i_func3)
            F3_B:  o_data = {{(DATA_WIDTH-8){w_shifted[7]}},   w_shifted[7:0]};
            F3_H:  o_data = {{(DATA_WIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
            F3_W:  o_data = {{(DATA_WIDTH-32){w_shifted[31]}}, w_shifted[31:0]};
            F3_D:  o_data = w_shifted;
            F3_BU: o_data = {{(DATA_WIDTH-8){1'b0}},  w_shifted[7:0]};
            F3_HU: o_data = {{(DATA_WIDTH-16){1'b0}}, w_shifted[15:0]};
            F3_WU: o_data = {{(DATA_WIDTH-32){1'b0}}, w_shifted[31:0]};
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: one strobed 64-bit access per packet, load extension, faulting of bad accesses,
// and a valid/ready writeback packet towards the register file.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned REG_ADDR_WIDTH  = 5,
    parameter int unsigned ALU_FUNC3_WIDTH = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [6:0]                 in_opcode,
    input  logic [ALU_FUNC3_WIDTH-1:0] in_func3,
    input  logic [DATA_WIDTH-1:0]      in_alu_res,
    input  logic [DATA_WIDTH-1:0]      in_store_data,
    input  logic [REG_ADDR_WIDTH-1:0]  in_rd,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic [DATA_WIDTH-1:0]      mem_req_addr,
    output logic                       mem_req_we,
    output logic [DATA_WIDTH-1:0]      mem_req_wdata,
    output logic [7:0]                 mem_req_wstrb,
    input  logic                       mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]      mem_resp_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [REG_ADDR_WIDTH-1:0]  out_rd,
    output logic                       out_wen,
    output logic                       out_fault
);

    lsu_state_e r_state, w_next;

    logic                      w_accept, w_is_load, w_is_store, w_is_mem, w_fault;
    logic [DATA_WIDTH-1:0]     w_load_val;

    logic [2:0]                r_func3;
    logic [2:0]                r_offset;
    logic                      r_we;
    logic [REG_ADDR_WIDTH-1:0] r_rd;
    logic [DATA_WIDTH-1:0]     r_req_addr, r_req_wdata, r_out_data;
    logic [7:0]                r_req_wstrb;
    logic                      r_out_wen, r_out_fault;

    assign w_accept   = in_valid && in_ready;
    assign w_is_load  = (in_opcode == OPC_LOAD);
    assign w_is_store = (in_opcode == OPC_STORE);
    assign w_is_mem   = w_is_load || w_is_store;
    assign w_fault    = w_is_mem &&
                        ((w_is_load && in_func3[2:0] == 3'b111) ||
                         (w_is_store && in_func3[2]) ||
                         misaligned(in_func3[1:0], in_alu_res[2:0]));

    load_extract #(.DATA_WIDTH(DATA_WIDTH)) u_extract (
        .i_rdata  (mem_resp_rdata),
        .i_offset (r_offset),
        .i_func3  (r_func3),
        .o_data   (w_load_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        in_ready      = 1'b0;
        mem_req_valid = 1'b0;
        out_valid     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = rst_n;
                if (w_accept) w_next = (w_is_mem && !w_fault) ? ST_MEM_REQ : ST_OUT;
            end
            ST_MEM_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) w_next = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                if (mem_resp_valid) w_next = ST_OUT;
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_func3     <= '0;
            r_offset    <= '0;
            r_we        <= 1'b0;
            r_rd        <= '0;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_req_wstrb <= '0;
            r_out_data  <= '0;
            r_out_wen   <= 1'b0;
            r_out_fault <= 1'b0;
        end else if (w_accept) begin
            r_func3  <= in_func3[2:0];
            r_offset <= in_alu_res[2:0];
            r_rd     <= in_rd;
            if (w_fault) begin
                r_out_data  <= '0;
                r_out_wen   <= 1'b0;
                r_out_fault <= 1'b1;
            end else if (!w_is_mem) begin
                r_out_data  <= in_alu_res;
                r_out_wen   <= (in_rd != '0);
                r_out_fault <= 1'b0;
            end else begin
                r_we        <= w_is_store;
                r_req_addr  <= {in_alu_res[DATA_WIDTH-1:3], 3'b000};
                r_req_wdata <= w_is_store ? (in_store_data << {in_alu_res[2:0], 3'b000}) : '0;
                r_req_wstrb <= w_is_store ? (size_mask(in_func3[1:0]) << in_alu_res[2:0]) : '0;
                r_out_data  <= '0;
                r_out_wen   <= 1'b0;
                r_out_fault <= 1'b0;
            end
        end else if (r_state == ST_MEM_WAIT && mem_resp_valid) begin
            // Stores are acked by the same response pulse but never write a register.
            r_out_data <= r_we ? '0 : w_load_val;
            r_out_wen  <= !r_we && (r_rd != '0);
        end
    end

    assign mem_req_addr  = r_req_addr;
    assign mem_req_we    = r_we;
    assign mem_req_wdata = r_req_wdata;
    assign mem_req_wstrb = r_req_wstrb;
    assign out_data      = r_out_data;
    assign out_rd        = r_rd;
    assign out_wen       = r_out_wen;
    assign out_fault     = r_out_fault;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with hand-computed expected values.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [2:0]  in_func3;
    logic [63:0] in_alu_res;
    logic [63:0] in_store_data;
    logic [4:0]  in_rd;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_req_we;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wstrb;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic        out_fault;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    load_store_unit #(
        .DATA_WIDTH      (64),
        .REG_ADDR_WIDTH  (5),
        .ALU_FUNC3_WIDTH (3)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_opcode      (in_opcode),
        .in_func3       (in_func3),
        .in_alu_res     (in_alu_res),
        .in_store_data  (in_store_data),
        .in_rd          (in_rd),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_we     (mem_req_we),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wstrb  (mem_req_wstrb),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_rd         (out_rd),
        .out_wen        (out_wen),
        .out_fault      (out_fault)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [6:0] opc, input logic [2:0] f3, input logic [63:0] alu,
                        input logic [63:0] sd, input logic [4:0] rd);
        in_valid      = 1'b1;
        in_opcode     = opc;
        in_func3      = f3;
        in_alu_res    = alu;
        in_store_data = sd;
        in_rd         = rd;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mreqv"}, 64'(mem_req_valid), 64'h0);
        chk({tag, "_maddr"}, mem_req_addr, 64'h0);
        chk({tag, "_mwe"},   64'(mem_req_we), 64'h0);
        chk({tag, "_mwd"},   mem_req_wdata, 64'h0);
        chk({tag, "_mstrb"}, 64'(mem_req_wstrb), 64'h0);
        chk({tag, "_ovld"},  64'(out_valid), 64'h0);
        chk({tag, "_odata"}, out_data, 64'h0);
        chk({tag, "_ord"},   64'(out_rd), 64'h0);
        chk({tag, "_owen"},  64'(out_wen), 64'h0);
        chk({tag, "_oflt"},  64'(out_fault), 64'h0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_opcode = '0; in_func3 = '0; in_alu_res = '0;
        in_store_data = '0; in_rd = '0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        mem_resp_rdata = '0; out_ready = 1'b1;

        tick(); tick();
        chk("rst_in_ready", 64'(in_ready), 64'h0);
        chk_all_zero("rst");
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'h1);

        // Non-memory op, rd=5
        send(7'b0110011, 3'b000, 64'h1234, 64'h0, 5'd5);
        tick(); in_valid = 1'b0;
        chk("alu_ovld",  64'(out_valid), 64'h1);
        chk("alu_odata", out_data, 64'h1234);
        chk("alu_owen",  64'(out_wen), 64'h1);
        chk("alu_ord",   64'(out_rd), 64'h5);
        chk("alu_oflt",  64'(out_fault), 64'h0);
        chk("alu_inrdy", 64'(in_ready), 64'h0);
        chk("alu_mreqv", 64'(mem_req_valid), 64'h0);
        tick();
        chk("alu_back_idle", 64'(in_ready), 64'h1);
        chk("alu_ovld_lo",   64'(out_valid), 64'h0);

        // Non-memory op, rd=0
        send(7'b0110011, 3'b000, 64'h1234, 64'h0, 5'd0);
        tick(); in_valid = 1'b0;
        chk("rd0_ovld", 64'(out_valid), 64'h1);
        chk("rd0_owen", 64'(out_wen), 64'h0);
        tick();

        // lb 0x1003
        send(7'b0000011, 3'b000, 64'h1003, 64'h0, 5'd7);
        mem_req_ready = 1'b1;
        tick(); in_valid = 1'b0;
        chk("lb_mreqv", 64'(mem_req_valid), 64'h1);
        chk("lb_maddr", mem_req_addr, 64'h1000);
        chk("lb_mwe",   64'(mem_req_we), 64'h0);
        chk("lb_ovld0", 64'(out_valid), 64'h0);
        tick();
        chk("lb_wait_mreqv", 64'(mem_req_valid), 64'h0);
        mem_resp_valid = 1'b1; mem_resp_rdata = 64'h0000_0000_8000_0000;
        tick(); mem_resp_valid = 1'b0;
        chk("lb_ovld",  64'(out_valid), 64'h1);
        chk("lb_odata", out_data, 64'hFFFF_FFFF_FFFF_FF80);
        chk("lb_owen",  64'(out_wen), 64'h1);
        chk("lb_oflt",  64'(out_fault), 64'h0);
        tick();

        // lbu 0x1003
        send(7'b0000011, 3'b100, 64'h1003, 64'h0, 5'd7);
        tick(); in_valid = 1'b0;
        tick();
        mem_resp_valid = 1'b1;
        tick(); mem_resp_valid = 1'b0;
        chk("lbu_ovld",  64'(out_valid), 64'h1);
        chk("lbu_odata", out_data, 64'h80);
        tick();

        // lh 0x0012: halfword at bytes 2-3 is 0x8001
        send(7'b0000011, 3'b001, 64'h0012, 64'h0, 5'd9);
        tick(); in_valid = 1'b0;
        chk("lh_maddr", mem_req_addr, 64'h0010);
        tick();
        mem_resp_valid = 1'b1; mem_resp_rdata = 64'h0000_0000_8001_0000;
        tick(); mem_resp_valid = 1'b0;
        chk("lh_odata", out_data, 64'hFFFF_FFFF_FFFF_8001);
        tick();

        // sh 0x2006
        send(7'b0100011, 3'b001, 64'h2006, 64'hABCD, 5'd3);
        tick(); in_valid = 1'b0;
        chk("sh_mreqv", 64'(mem_req_valid), 64'h1);
        chk("sh_maddr", mem_req_addr, 64'h2000);
        chk("sh_mwe",   64'(mem_req_we), 64'h1);
        chk("sh_mstrb", 64'(mem_req_wstrb), 64'hC0);
        chk("sh_mwd",   mem_req_wdata, 64'hABCD_0000_0000_0000);
        tick();
        mem_resp_valid = 1'b1;
        tick(); mem_resp_valid = 1'b0;
        chk("sh_ovld", 64'(out_valid), 64'h1);
        chk("sh_owen", 64'(out_wen), 64'h0);
        chk("sh_oflt", 64'(out_fault), 64'h0);
        tick();

        // sw 0x4004
        send(7'b0100011, 3'b010, 64'h4004, 64'hFFFF_FFFF_1122_3344, 5'd3);
        tick(); in_valid = 1'b0;
        chk("sw_mstrb", 64'(mem_req_wstrb), 64'hF0);
        chk("sw_mwd",   mem_req_wdata, 64'h1122_3344_0000_0000);
        tick();
        mem_resp_valid = 1'b1;
        tick(); mem_resp_valid = 1'b0;
        tick();

        // lw 0x1002: misaligned
        send(7'b0000011, 3'b010, 64'h1002, 64'h0, 5'd4);
        tick(); in_valid = 1'b0;
        chk("lwmis_mreqv", 64'(mem_req_valid), 64'h0);
        chk("lwmis_ovld",  64'(out_valid), 64'h1);
        chk("lwmis_oflt",  64'(out_fault), 64'h1);
        chk("lwmis_owen",  64'(out_wen), 64'h0);
        chk("lwmis_odata", out_data, 64'h0);
        tick();

        // store func3=100: illegal
        send(7'b0100011, 3'b100, 64'h5000, 64'h1, 5'd4);
        tick(); in_valid = 1'b0;
        chk("still_mreqv", 64'(mem_req_valid), 64'h0);
        chk("still_oflt",  64'(out_fault), 64'h1);
        tick();

        // ld 0x3008 with req backpressure, then writeback backpressure
        mem_req_ready = 1'b0;
        send(7'b0000011, 3'b011, 64'h3008, 64'h0, 5'd10);
        tick(); in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("ld_bp_mreqv", 64'(mem_req_valid), 64'h1);
            chk("ld_bp_maddr", mem_req_addr, 64'h3008);
            chk("ld_bp_mwe",   64'(mem_req_we), 64'h0);
            chk("ld_bp_inrdy", 64'(in_ready), 64'h0);
            tick();
        end
        chk("ld_bp_mreqv3", 64'(mem_req_valid), 64'h1);
        mem_req_ready = 1'b1;
        tick();
        chk("ld_wait_inrdy", 64'(in_ready), 64'h0);
        out_ready = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_rdata = 64'h1122_3344_5566_7788;
        tick(); mem_resp_valid = 1'b0; mem_resp_rdata = 64'h0;
        for (int i = 0; i < 3; i++) begin
            chk("ld_ohold_ovld",  64'(out_valid), 64'h1);
            chk("ld_ohold_odata", out_data, 64'h1122_3344_5566_7788);
            chk("ld_ohold_ord",   64'(out_rd), 64'd10);
            chk("ld_ohold_owen",  64'(out_wen), 64'h1);
            chk("ld_ohold_inrdy", 64'(in_ready), 64'h0);
            if (i < 2) tick();
        end
        out_ready = 1'b1;
        tick();
        chk("ld_done_ovld",  64'(out_valid), 64'h0);
        chk("ld_done_inrdy", 64'(in_ready), 64'h1);

        // Reset during MEM_WAIT, late response ignored
        send(7'b0000011, 3'b011, 64'h6000, 64'h0, 5'd11);
        tick(); in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("rstw_inrdy", 64'(in_ready), 64'h0);
        chk_all_zero("rstw");
        tick();
        rst_n = 1'b1;
        mem_resp_valid = 1'b1; mem_resp_rdata = 64'hDEAD_BEEF_0000_0001;
        tick(); mem_resp_valid = 1'b0;
        chk_all_zero("late");
        chk("late_inrdy", 64'(in_ready), 64'h1);
        send(7'b0010011, 3'b000, 64'h55, 64'h0, 5'd3);
        tick(); in_valid = 1'b0;
        chk("addi_ovld",  64'(out_valid), 64'h1);
        chk("addi_odata", out_data, 64'h55);
        chk("addi_owen",  64'(out_wen), 64'h1);
        chk("addi_oflt",  64'(out_fault), 64'h0);
        tick();
        chk("addi_idle", 64'(in_ready), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory stage directly downstream of the execute ALU. Takes the ALU result (effective address for loads/stores, final value otherwise), performs at most one 64-bit memory transaction with byte strobes, aligns and sign/zero-extends load data, and hands a writeback packet to the register-file stage over a valid/ready handshake. Misaligned or illegal accesses never reach memory and are reported as faults.
## Interface
- DATA_WIDTH, 64, datapath and address width
- REG_ADDR_WIDTH, 5, destination register index width
- ALU_FUNC3_WIDTH, 3, func3 width
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  execute packet valid
- in_ready  out  1  block can accept (high only in IDLE)
- in_opcode  in  7  instruction opcode
- in_func3  in  ALU_FUNC3_WIDTH  access size/sign
- in_alu_res  in  DATA_WIDTH  ALU result / effective address
- in_store_data  in  DATA_WIDTH  rs2 value for stores
- in_rd  in  REG_ADDR_WIDTH  destination register
- mem_req_valid / mem_req_ready  out / in  1  memory request handshake
- mem_req_addr  out  DATA_WIDTH  address with [2:0] forced to 0
- mem_req_we  out  1  1 = store
- mem_req_wdata  out  DATA_WIDTH  store data shifted to byte lane
- mem_req_wstrb  out  8  byte enables
- mem_resp_valid  in  1  one-cycle response pulse (also acks stores)
- mem_resp_rdata  in  DATA_WIDTH  aligned 64-bit read data
- out_valid / out_ready  out / in  1  writeback handshake
- out_data  out  DATA_WIDTH  writeback value
- out_rd  out  REG_ADDR_WIDTH  writeback register
- out_wen  out  1  register write enable
- out_fault  out  1  misaligned/illegal access flag
## Operation
- States IDLE, MEM_REQ, MEM_WAIT, OUT. Packet captured into registers on in_valid && in_ready.
- Load = 0000011, store = 0100011; any other opcode: IDLE->OUT, out_data = in_alu_res, out_wen = (rd != 0).
- Load func3: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu; 111 illegal. Store func3: 000 sb, 001 sh, 010 sw, 011 sd; >=100 illegal.
- Misaligned: half addr[0]!=0, word addr[1:0]!=0, dword addr[2:0]!=0. Misaligned or illegal: IDLE->OUT with out_fault=1, out_wen=0, out_data=0, no memory request.
- Legal access: IDLE->MEM_REQ; mem_req_valid held with all req fields stable until mem_req_ready; then MEM_WAIT.
- Store: wstrb = size mask (0x01/0x03/0x0F/0xFF) << addr[2:0]; wdata = store_data << 8*addr[2:0]; out_wen=0.
- Load: rdata >> 8*addr[2:0], then sign/zero-extend per func3; out_wen = (rd != 0).
- MEM_WAIT->OUT on mem_resp_valid, data latched. mem_resp_valid in any other state ignored.
- OUT->IDLE on out_ready; out_* stable while out_valid && !out_ready.
## Timing
- Reset: state IDLE; in_ready=0 during reset, 1 first cycle after; all other outputs 0.
- Non-memory / fault packet accepted at cycle T: out_valid at T+1.
- Memory packet accepted at T: mem_req_valid at T+1; resp at earliest cycle after req accepted; out_valid the cycle after resp (minimum T+3).
- No accept in OUT even with out_ready=1; next accept at earliest the cycle after OUT->IDLE. One packet in flight.
- rst_n low in any state: immediate return to IDLE, outputs 0, in-flight transaction dropped; late responses ignored.
## Structure
- Package lsu_pkg: load/store opcode constants, func3 constants, state enum, size-mask constants.
- Sub-module load_extract (combinational: rdata, addr[2:0], func3 -> extended 64-bit value).
## Test plan
- opcode 0110011, alu_res 0x1234, rd 5, out_ready=1 -> out_valid at T+1, out_data 0x1234, out_wen 1; repeat with rd 0 -> out_wen 0.
- lb addr 0x1003, rdata 0x0000_0000_8000_0000 -> mem_req_addr 0x1000, we 0, out_data 0xFFFF_FFFF_FFFF_FF80; lbu same -> 0x80.
- sh addr 0x2006, store_data 0xABCD -> wstrb 0xC0, wdata[63:48]=0xABCD, out_wen 0, out_fault 0.
- lw addr 0x1002 -> no mem_req_valid, out_valid T+1 with out_fault 1, out_wen 0, out_data 0.
- ld with mem_req_ready low 3 cycles, then out_ready low 2 cycles -> req fields and out_* held stable, in_ready 0 throughout.
- rst_n pulsed low in MEM_WAIT, resp arrives after release -> ignored, all outputs 0; next addi packet completes normally at T+1.
